com_responder: RTL and testbench

COM_RESPONDER -- requirements
Module: com_responder

---
 rtl/com_pkg.sv | 19 +
 rtl/word_serializer.sv | 39 +++
 rtl/com_responder.sv | 110 +++++++++++
 tb/tb_com_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// Shared types and defaults for the COM responder.
// Holds the FSM state encoding and word/byte sizing constants.
package com_pkg;

  localparam int ADDR_W_DEF     = 18;
  localparam int DATA_W_DEF     = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = DATA_W_DEF / BYTE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_ACK,
    S_DONE
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// Word-to-byte serializer: loads one memory word, shifts it out MSB first.
// last flags the final byte of the word.
module word_serializer
  import com_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              shift,
  output logic [7:0]        dout,
  output logic              last
);

  localparam int NB = DATA_W / BYTE_W;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_W-1:0] sr;
  logic [IW-1:0]     idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= din;
      idx <= '0;
    end else if (shift) begin
      sr  <= sr << BYTE_W;
      idx <= idx + IW'(1);
    end
  end

  assign dout = sr[DATA_W-1 -: BYTE_W];
  assign last = (idx == IW'(NB - 1));

endmodule

// File: rtl/com_responder.sv
// COM responder: streams a block of data-memory words to the host
// interpreter byte by byte, then waits for the host to acknowledge.
module com_responder
  import com_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              com_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              host_ack,
  output logic              busy,
  output logic              com_done
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              xfer;
  logic              ser_last;
  logic              ser_load;
  logic              ser_shift;

  assign xfer      = tx_valid & tx_ready;
  assign ser_load  = (state == S_WAIT);
  assign ser_shift = (state == S_SEND) & xfer;

  word_serializer #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk  (clk),
    .reset(reset),
    .load (ser_load),
    .din  (mem_rdata),
    .shift(ser_shift),
    .dout (tx_data),
    .last (ser_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      com_done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (com_start) begin
            mem_addr <= base_addr;
            cnt      <= word_count;
            busy     <= 1'b1;
            if (word_count == '0) begin
              state <= S_ACK;
            end else begin
              state     <= S_READ;
              mem_rd_en <= 1'b1;
            end
          end
        end
        S_READ: begin
          mem_rd_en <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          tx_valid <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          // Address wraps naturally at ADDR_W bits
          if (xfer && ser_last) begin
            tx_valid <= 1'b0;
            mem_addr <= mem_addr + ADDR_W'(4);
            cnt      <= cnt - ADDR_W'(1);
            if (cnt == ADDR_W'(1)) begin
              state <= S_ACK;
            end else begin
              state     <= S_READ;
              mem_rd_en <= 1'b1;
            end
          end
        end
        S_ACK: begin
          if (host_ack) begin
            com_done <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          com_done <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_com_responder.sv
// Directed bench for com_responder with byte and address scoreboards.
module tb_com_responder;

  logic        clk;
  logic        reset;
  logic        com_start;
  logic [17:0] base_addr;
  logic [17:0] word_count;
  logic        mem_rd_en;
  logic [17:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        host_ack;
  logic        busy;
  logic        com_done;

  com_responder #(.ADDR_W(18), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .com_start (com_start),
    .base_addr (base_addr),
    .word_count(word_count),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .host_ack  (host_ack),
    .busy      (busy),
    .com_done  (com_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rd_seen = 0;
  int tx_seen = 0;
  int done_seen = 0;
  int rd0, tx0, d0;

  logic [7:0]  exp_q[$];
  logic [17:0] aq[$];
  logic [31:0] mem [logic [17:0]];
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(posedge clk)
    if (mem_rd_en)
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mem_rd_en) begin
        rd_seen++;
        checks++;
        assert (aq.size() != 0) else begin
          errors++;
          $error("FAIL rd_extra observed=%0h expected=none", mem_addr);
        end
        if (aq.size() != 0) chk("mem_addr", mem_addr, aq.pop_front());
      end
      if (tx_valid) begin
        if (stall_prev) chk("tx_stable", tx_data, prev_data);
        if (tx_ready) begin
          tx_seen++;
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL tx_extra observed=%0h expected=none", tx_data);
          end
          if (exp_q.size() != 0) chk("tx_data", tx_data, exp_q.pop_front());
        end
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (com_done) done_seen++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [17:0] a);
    logic [31:0] w;
    w = mem.exists(a) ? mem[a] : 32'h0;
    aq.push_back(a);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic start(input logic [17:0] b, input logic [17:0] c);
    rd0 = rd_seen;
    tx0 = tx_seen;
    d0  = done_seen;
    base_addr  = b;
    word_count = c;
    com_start  = 1'b1;
    tick();
    com_start  = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic drain(input int mode, input int exp_cycles);
    int n;
    logic [3:0] pat;
    pat = 4'b1001;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (mode == 1) tx_ready = pat[3 - (n % 4)];
      if (mode == 2 && n == 3) begin
        com_start = 1'b1;
        host_ack  = 1'b1;
        base_addr = 18'h3FFFC;
        word_count = 18'd1;
      end else begin
        com_start = 1'b0;
        host_ack  = 1'b0;
      end
      tick();
      n++;
    end
    com_start = 1'b0;
    host_ack  = 1'b0;
    tx_ready  = 1'b1;
    chk("drain_left", exp_q.size(), 0);
    if (exp_cycles >= 0) chk("throughput", n, exp_cycles);
  endtask

  task automatic finish_xfer(input int exp_reads, input int exp_bytes);
    tick();
    chk("ack_tx_valid", tx_valid, 0);
    chk("ack_busy", busy, 1);
    chk("ack_no_done", done_seen - d0, 0);
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    chk("com_done_pulse", com_done, 1);
    chk("busy_released", busy, 0);
    tick();
    chk("com_done_low", com_done, 0);
    chk("done_count", done_seen - d0, 1);
    chk("read_count", rd_seen - rd0, exp_reads);
    chk("byte_count", tx_seen - tx0, exp_bytes);
    chk("addr_left", aq.size(), 0);
  endtask

  initial begin
    mem[18'h00010] = 32'hDEADBEEF;
    mem[18'h00014] = 32'h01020304;
    mem[18'h3FFFC] = 32'hCAFEF00D;
    mem[18'h00000] = 32'hA5A50F0F;
    reset = 1'b0;
    com_start = 1'b0;
    base_addr = '0;
    word_count = '0;
    tx_ready = 1'b1;
    host_ack = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_done", com_done, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b1;

    // two words, back-to-back, 6 cycles per word
    push_word(18'h10);
    push_word(18'h14);
    start(18'h10, 18'd2);
    drain(0, 12);
    finish_xfer(2, 8);

    // zero words, with host_ack coincident with the start
    host_ack = 1'b1;
    start(18'h10, 18'd0);
    host_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("zero_busy", busy, 1);
    chk("zero_tx_valid", tx_valid, 0);
    finish_xfer(0, 0);

    // tx_ready 1-0-0-1 backpressure
    push_word(18'h10);
    push_word(18'h14);
    start(18'h10, 18'd2);
    drain(1, -1);
    finish_xfer(2, 8);

    // address wrap
    push_word(18'h3FFFC);
    push_word(18'h00000);
    start(18'h3FFFC, 18'd2);
    drain(0, 12);
    finish_xfer(2, 8);

    // stray com_start/host_ack during SEND
    push_word(18'h10);
    push_word(18'h14);
    start(18'h10, 18'd2);
    drain(2, 12);
    finish_xfer(2, 8);

    // reset while the third byte is on the bus
    push_word(18'h10);
    push_word(18'h14);
    start(18'h10, 18'd2);
    tick();
    tick();
    tick();
    tick();
    chk("pre_rst_byte", tx_data, 8'hBE);
    reset = 1'b0;
    #1;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_tx_data", tx_data, 0);
    exp_q.delete();
    aq.delete();
    tick();
    reset = 1'b1;
    chk("abort_no_done", done_seen - d0, 0);
    push_word(18'h10);
    push_word(18'h14);
    start(18'h10, 18'd2);
    drain(0, 12);
    finish_xfer(2, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
